// File: rtl/pixel_fetch.sv
// Pixel fetch engine: turns (x,y) pixel requests into 2-cycle SRAM reads and
// returns RGB888 colours in request order through a small credit-managed FIFO.
module pixel_fetch #(
   parameter int          ADDR_W   = 20,
   parameter int          DATA_W   = 16,
   parameter int          H_W      = 10,
   parameter int          V_W      = 9,
   parameter int          DEPTH    = 4,
   parameter int          VIS_W    = 640,
   parameter int          VIS_H    = 480,
   parameter logic [23:0] BG_COLOR = 24'h000000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [H_W-1:0]    i_req_x,
   input  logic [V_W-1:0]    i_req_y,
   input  logic              i_sram_busy,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_sram_rd,
   input  logic [DATA_W-1:0] i_sram_data,
   output logic [23:0]       o_color,
   output logic              o_color_valid,
   input  logic              i_color_ready,
   output logic [7:0]        o_corrupt_cnt,
   output logic [1:0]        o_state
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SUM_W = CNT_W + 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_FLUSH = 2'd2} state_t;

   function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
      return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   state_t            state_q, state_d;
   logic              s1_valid_q, s1_valid_d, s1_inr_q, s1_inr_d;
   logic              s2_valid_q, s2_valid_d, s2_inr_q, s2_inr_d;
   logic [23:0]       fifo_mem_q [DEPTH];
   logic [23:0]       fifo_mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [7:0]        corrupt_cnt_q, corrupt_cnt_d;

   logic              in_range_s, ready_s, accept_s, clear_s;
   logic              push_s, pop_s, corrupt_s;
   logic [SUM_W-1:0]  credit_used_s;
   logic [23:0]       push_color_s;

   // Next-state logic for the IDLE / FETCH / FLUSH controller
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = i_flush ? ST_IDLE  : ST_FETCH;
         ST_FETCH: state_d = i_flush ? ST_FLUSH : ST_FETCH;
         ST_FLUSH: state_d = i_flush ? ST_FLUSH : ST_FETCH;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Request acceptance, credit check and SRAM read issue
   always_comb begin
      in_range_s    = (i_req_x < H_W'(VIS_W)) && (i_req_y < V_W'(VIS_H));
      credit_used_s = SUM_W'(count_q) + SUM_W'(s1_valid_q) + SUM_W'(s2_valid_q);
      ready_s       = (state_q == ST_FETCH) && !i_sram_busy && (credit_used_s < SUM_W'(DEPTH));
      // A flush in the same cycle cancels the accept.
      accept_s      = i_req_valid && ready_s && !i_flush;
      clear_s       = i_flush || (state_q == ST_FLUSH);
      o_req_ready   = ready_s;
      o_sram_rd     = accept_s && in_range_s;
      o_sram_addr   = o_sram_rd ? ADDR_W'({i_req_y, i_req_x}) : {ADDR_W{1'b0}};
   end

   // Two-stage tag pipeline and capture of the returning read data
   always_comb begin
      s1_valid_d    = clear_s ? 1'b0 : accept_s;
      s1_inr_d      = in_range_s;
      s2_valid_d    = clear_s ? 1'b0 : s1_valid_q;
      s2_inr_d      = s1_inr_q;
      push_s        = s2_valid_q && !clear_s;
      corrupt_s     = push_s && s2_inr_q && i_sram_busy;
      push_color_s  = (s2_inr_q && !i_sram_busy) ? rgb565_to_888(i_sram_data[15:0]) : BG_COLOR;
      corrupt_cnt_d = (corrupt_s && (corrupt_cnt_q != 8'hFF)) ? corrupt_cnt_q + 8'd1 : corrupt_cnt_q;
   end

   // Output FIFO bookkeeping
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      pop_s      = (count_q != {CNT_W{1'b0}}) && i_color_ready;
      if (clear_s) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            fifo_mem_d[wr_ptr_q] = push_color_s;
            wr_ptr_d             = next_ptr(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         rd_ptr_d = pop_s ? next_ptr(rd_ptr_q) : rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State, pipeline and FIFO registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         s1_valid_q    <= 1'b0;
         s1_inr_q      <= 1'b0;
         s2_valid_q    <= 1'b0;
         s2_inr_q      <= 1'b0;
         wr_ptr_q      <= {PTR_W{1'b0}};
         rd_ptr_q      <= {PTR_W{1'b0}};
         count_q       <= {CNT_W{1'b0}};
         corrupt_cnt_q <= 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_mem_q[i] <= BG_COLOR;
         end
      end else begin
         state_q       <= state_d;
         s1_valid_q    <= s1_valid_d;
         s1_inr_q      <= s1_inr_d;
         s2_valid_q    <= s2_valid_d;
         s2_inr_q      <= s2_inr_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         corrupt_cnt_q <= corrupt_cnt_d;
         fifo_mem_q    <= fifo_mem_d;
      end
   end

   assign o_color_valid = (count_q != {CNT_W{1'b0}});
   assign o_color       = o_color_valid ? fifo_mem_q[rd_ptr_q] : BG_COLOR;
   assign o_corrupt_cnt = corrupt_cnt_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch: expected colours are queued at request
// accept from a bench-side SRAM model and compared as the FIFO delivers them.
module tb_pixel_fetch;
   localparam logic [23:0] BG = 24'h000000;

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_flush, i_req_valid, o_req_ready;
   logic [9:0]  i_req_x;
   logic [8:0]  i_req_y;
   logic        i_sram_busy, o_sram_rd, o_color_valid, i_color_ready;
   logic [19:0] o_sram_addr;
   logic [15:0] i_sram_data;
   logic [23:0] o_color;
   logic [7:0]  o_corrupt_cnt;
   logic [1:0]  o_state;

   int          n_checks = 0;
   int          n_errors = 0;
   int          acc_cnt  = 0;
   logic [23:0] sb[$];

   logic        sram_force = 1'b0;
   logic [15:0] sram_force_val = 16'h0000;
   logic        a1_v = 1'b0, a2_v = 1'b0;
   logic [19:0] a1_addr = 20'h0, a2_addr = 20'h0;

   pixel_fetch dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_x(i_req_x), .i_req_y(i_req_y), .i_sram_busy(i_sram_busy),
      .o_sram_addr(o_sram_addr), .o_sram_rd(o_sram_rd), .i_sram_data(i_sram_data),
      .o_color(o_color), .o_color_valid(o_color_valid), .i_color_ready(i_color_ready),
      .o_corrupt_cnt(o_corrupt_cnt), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] mem_fn(input logic [19:0] a);
      return a[15:0] ^ {a[19:16], a[11:0]} ^ 16'h5A3C;
   endfunction

   function automatic logic [23:0] expand(input logic [15:0] d);
      logic [7:0] r, g, b;
      r = {d[15:11], d[15:13]};
      g = {d[10:5], d[10:9]};
      b = {d[4:0], d[4:2]};
      return {r, g, b};
   endfunction

   // SRAM model: data for a read issued in cycle t is presented during cycle t+2
   always @(posedge i_clk) begin
      a1_v    <= o_sram_rd;
      a1_addr <= o_sram_addr;
      a2_v    <= a1_v;
      a2_addr <= a1_addr;
   end
   assign i_sram_data = sram_force ? sram_force_val : (a2_v ? mem_fn(a2_addr) : 16'hDEAD);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Consumer side: every delivered pixel is matched against the scoreboard head
   always @(negedge i_clk) begin
      if (o_color_valid === 1'b1 && i_color_ready === 1'b1) begin
         if (sb.size() == 0) chk("unexpected_pixel", 32'(o_color), 32'hFFFFFFFF);
         else chk("color", 32'(o_color), 32'(sb.pop_front()));
      end
   end

   // Called at the negedge of an accept cycle: checks the read strobe and queues the pixel
   task automatic accept_push(input bit corrupt);
      logic        inr;
      logic [19:0] ea;
      inr = (i_req_x < 10'd640) && (i_req_y < 9'd480);
      ea  = {1'b0, i_req_y, i_req_x};
      chk("sram_rd", 32'(o_sram_rd), 32'(inr));
      chk("sram_addr", 32'(o_sram_addr), inr ? 32'(ea) : 32'h0);
      if (!inr || corrupt) sb.push_back(BG);
      else sb.push_back(expand(sram_force ? sram_force_val : mem_fn(ea)));
      acc_cnt++;
   endtask

   task automatic send(input logic [9:0] x, input logic [8:0] y, input bit corrupt);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      i_req_valid = 1'b1;
      i_req_x = x;
      i_req_y = y;
      while (!done) begin
         @(negedge i_clk);
         if (o_req_ready) begin
            accept_push(corrupt);
            done = 1'b1;
         end else if (++n > 200) begin
            chk("accept_timeout", 32'(n), 32'd0);
            done = 1'b1;
         end
         @(posedge i_clk); #1;
      end
      i_req_valid = 1'b0;
      if (corrupt) begin
         @(posedge i_clk); #1;
         i_sram_busy = 1'b1;
         @(posedge i_clk); #1;
         i_sram_busy = 1'b0;
      end
   endtask

   task automatic stream(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         i_req_valid = 1'b1;
         i_req_x = 10'(i + 20);
         i_req_y = 9'd7;
         @(negedge i_clk);
         if (o_req_ready) accept_push(1'b0);
         @(posedge i_clk); #1;
      end
      i_req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge i_clk);
      chk("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge i_clk); #1;
   endtask

   initial begin
      int acc0;
      i_rst_n = 1'b0; i_flush = 1'b0; i_req_valid = 1'b0; i_req_x = 10'd0; i_req_y = 9'd0;
      i_sram_busy = 1'b0; i_color_ready = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("rst_state", 32'(o_state), 32'd0);
      chk("rst_ready", 32'(o_req_ready), 32'd0);
      chk("rst_rd", 32'(o_sram_rd), 32'd0);
      chk("rst_color", 32'(o_color), 32'(BG));
      chk("rst_valid", 32'(o_color_valid), 32'd0);
      chk("rst_corrupt", 32'(o_corrupt_cnt), 32'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      chk("idle_to_fetch", 32'(o_state), 32'd1);

      // Single read with latency checks
      sram_force = 1'b1; sram_force_val = 16'hF800;
      send(10'd5, 9'd3, 1'b0);
      @(negedge i_clk); chk("lat_t1", 32'(o_color_valid), 32'd0);
      @(negedge i_clk); chk("lat_t2", 32'(o_color_valid), 32'd0);
      @(negedge i_clk); chk("lat_t3", 32'(o_color_valid), 32'd1);
      chk("red", 32'(o_color), 32'hFF0000);
      sram_force = 1'b0;
      drain();

      // Out-of-range pixel between in-range neighbours, then boundary mix
      send(10'd1, 9'd1, 1'b0);
      send(10'd700, 9'd10, 1'b0);
      send(10'd2, 9'd1, 1'b0);
      send(10'd639, 9'd479, 1'b0);
      send(10'd640, 9'd0, 1'b0);
      send(10'd0, 9'd480, 1'b0);
      send(10'd123, 9'd321, 1'b0);
      drain();

      // First corrupt read
      send(10'd9, 9'd9, 1'b1);
      drain();
      chk("corrupt_one", 32'(o_corrupt_cnt), 32'd1);

      // Back-pressure: exactly DEPTH accepts, one pop releases one credit
      i_color_ready = 1'b0;
      acc0 = acc_cnt;
      stream(20);
      chk("bp_accepts", 32'(acc_cnt - acc0), 32'd4);
      chk("bp_ready_low", 32'(o_req_ready), 32'd0);
      i_color_ready = 1'b1;
      @(posedge i_clk); #1;
      i_color_ready = 1'b0;
      stream(10);
      chk("bp_after_pop", 32'(acc_cnt - acc0), 32'd5);
      i_color_ready = 1'b1;
      drain();

      // Flush with two buffered and two in flight
      i_color_ready = 1'b0;
      send(10'd40, 9'd1, 1'b0);
      send(10'd41, 9'd1, 1'b0);
      repeat (4) @(posedge i_clk); #1;
      send(10'd42, 9'd1, 1'b0);
      send(10'd43, 9'd1, 1'b0);
      i_flush = 1'b1;
      sb.delete();
      @(posedge i_clk); #1;
      chk("flush_valid", 32'(o_color_valid), 32'd0);
      chk("flush_state", 32'(o_state), 32'd2);
      chk("flush_ready", 32'(o_req_ready), 32'd0);
      i_flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         chk("flush_no_late_push", 32'(o_color_valid), 32'd0);
      end
      chk("flush_back_fetch", 32'(o_state), 32'd1);
      chk("flush_keeps_corrupt", 32'(o_corrupt_cnt), 32'd1);
      i_color_ready = 1'b1;
      @(posedge i_clk); #1;
      send(10'd44, 9'd2, 1'b0);
      drain();

      // Saturate the corrupt counter
      for (int i = 0; i < 299; i++) send(10'(i % 600), 9'd20, 1'b1);
      drain();
      chk("corrupt_sat", 32'(o_corrupt_cnt), 32'd255);

      // Reset while pixels are buffered
      i_color_ready = 1'b0;
      send(10'd30, 9'd4, 1'b0);
      send(10'd31, 9'd4, 1'b0);
      repeat (4) @(posedge i_clk);
      #2;
      chk("pre_rst_valid", 32'(o_color_valid), 32'd1);
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_state", 32'(o_state), 32'd0);
      chk("mid_rst_valid", 32'(o_color_valid), 32'd0);
      chk("mid_rst_color", 32'(o_color), 32'(BG));
      chk("mid_rst_ready", 32'(o_req_ready), 32'd0);
      chk("mid_rst_addr", 32'(o_sram_addr), 32'd0);
      chk("mid_rst_corrupt", 32'(o_corrupt_cnt), 32'd0);
      sb.delete();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_color_ready = 1'b1;
      @(posedge i_clk); #1;
      chk("post_rst_fetch", 32'(o_state), 32'd1);
      send(10'd5, 9'd3, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
